// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_unit
// Description : Pipelined control unit for a 5-stage RISC-V datapath. Decodes
//               the ID instruction, carries the control bundle through
//               ID/EX, EX/MEM and MEM/WB, resolves branches in EX and
//               generates stall / flush / PC-select.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
  parameter int SHAMT_W        = 6,
  parameter bit LOADUSE_STALL  = 1'b1,
  parameter int BR_FLUSH_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        id_ir,
  input  logic               id_valid,
  input  logic               cf,
  input  logic               zf,
  input  logic               vf,
  input  logic               sf,
  output logic [3:0]         ex_alufn,
  output logic               ex_alusrc,
  output logic [SHAMT_W-1:0] ex_shamt,
  output logic               mem_read,
  output logic               mem_write,
  output logic [1:0]         mem_sizesel,
  output logic               mem_unsigned,
  output logic               wb_regwrite,
  output logic               wb_memtoreg,
  output logic [1:0]         wb_regwritesrc,
  output logic [4:0]         wb_rd,
  output logic [1:0]         pc_sel,
  output logic               stall,
  output logic               flush_ifid,
  output logic               hazard_loaduse
);

  // ALU function codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd15;

  // Opcodes
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_ARITHR = 7'b0110011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Branch types held in ID/EX
  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_EQ   = 4'd1;
  localparam logic [3:0] BR_NE   = 4'd2;
  localparam logic [3:0] BR_LT   = 4'd3;
  localparam logic [3:0] BR_GE   = 4'd4;
  localparam logic [3:0] BR_LTU  = 4'd5;
  localparam logic [3:0] BR_GEU  = 4'd6;
  localparam logic [3:0] BR_JAL  = 4'd7;
  localparam logic [3:0] BR_JALR = 4'd8;

  // R-type shift amount is the full-width marker value
  localparam logic [SHAMT_W-1:0] C_SHAMT_R = SHAMT_W'(1) << (SHAMT_W - 1);

  typedef struct packed {
    logic [3:0]         alufn;
    logic               alusrc;
    logic [SHAMT_W-1:0] shamt;
    logic               mem_read;
    logic               mem_write;
    logic [1:0]         sizesel;
    logic               munsigned;
    logic               regwrite;
    logic               memtoreg;
    logic [1:0]         rwsrc;
    logic [4:0]         rd;
    logic [3:0]         br;
  } ex_bundle_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [1:0] sizesel;
    logic       munsigned;
    logic       regwrite;
    logic       memtoreg;
    logic [1:0] rwsrc;
    logic [4:0] rd;
  } mem_bundle_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic [1:0] rwsrc;
    logic [4:0] rd;
  } wb_bundle_t;

  function automatic ex_bundle_t nop_bundle();
    ex_bundle_t b;
    b       = '0;
    b.alufn = ALU_PASS;
    return b;
  endfunction

  function automatic logic [3:0] arith_fn(input logic [2:0] f3, input logic alt_add,
                                          input logic alt_shift);
    case (f3)
      3'b000:  return alt_add ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt_shift ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic [1:0] size_of(input logic [1:0] f3lo);
    case (f3lo)
      2'b00:   return 2'b01;
      2'b01:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_unused_ir;
  ex_bundle_t  w_dec;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_taken;
  ex_bundle_t  id_ex_d,  id_ex_q;
  mem_bundle_t ex_mem_d, ex_mem_q;
  wb_bundle_t  mem_wb_d, mem_wb_q;

  assign w_opcode    = id_ir[6:0];
  assign w_rd        = id_ir[11:7];
  assign w_f3        = id_ir[14:12];
  assign w_rs1       = id_ir[19:15];
  assign w_rs2       = id_ir[24:20];
  assign w_unused_ir = ^{id_ir[31], id_ir[29:25]};

  // Decode the ID instruction into a control bundle and its source usage
  always_comb begin
    w_dec     = nop_bundle();
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    if (id_valid) begin
      case (w_opcode)
        OP_BRANCH: begin
          w_dec.alufn = ALU_SUB;
          w_use_rs1   = 1'b1;
          w_use_rs2   = 1'b1;
          case (w_f3)
            3'b000:  w_dec.br = BR_EQ;
            3'b001:  w_dec.br = BR_NE;
            3'b100:  w_dec.br = BR_LT;
            3'b101:  w_dec.br = BR_GE;
            3'b110:  w_dec.br = BR_LTU;
            3'b111:  w_dec.br = BR_GEU;
            default: w_dec.br = BR_NONE;
          endcase
        end
        OP_LOAD: begin
          w_dec.alufn     = ALU_ADD;
          w_dec.alusrc    = 1'b1;
          w_dec.shamt     = SHAMT_W'(w_rs2);
          w_dec.mem_read  = 1'b1;
          w_dec.sizesel   = size_of(w_f3[1:0]);
          w_dec.munsigned = (w_f3 == 3'b100) || (w_f3 == 3'b101);
          w_dec.regwrite  = 1'b1;
          w_dec.memtoreg  = 1'b1;
          w_dec.rwsrc     = 2'b10;
          w_use_rs1       = 1'b1;
        end
        OP_STORE: begin
          w_dec.alufn     = ALU_ADD;
          w_dec.alusrc    = 1'b1;
          w_dec.mem_write = 1'b1;
          w_dec.sizesel   = size_of(w_f3[1:0]);
          w_use_rs1       = 1'b1;
          w_use_rs2       = 1'b1;
        end
        OP_JAL: begin
          w_dec.regwrite = 1'b1;
          w_dec.rwsrc    = 2'b01;
          w_dec.br       = BR_JAL;
        end
        OP_JALR: begin
          w_dec.alufn    = ALU_ADD;
          w_dec.alusrc   = 1'b1;
          w_dec.shamt    = SHAMT_W'(w_rs2);
          w_dec.regwrite = 1'b1;
          w_dec.rwsrc    = 2'b01;
          w_dec.br       = BR_JALR;
          w_use_rs1      = 1'b1;
        end
        OP_ARITHI: begin
          w_dec.alufn    = arith_fn(w_f3, 1'b0, id_ir[30]);
          w_dec.alusrc   = 1'b1;
          w_dec.shamt    = SHAMT_W'(w_rs2);
          w_dec.regwrite = 1'b1;
          w_dec.rwsrc    = 2'b10;
          w_use_rs1      = 1'b1;
        end
        OP_ARITHR: begin
          w_dec.alufn    = arith_fn(w_f3, id_ir[30], id_ir[30]);
          w_dec.shamt    = C_SHAMT_R;
          w_dec.regwrite = 1'b1;
          w_dec.rwsrc    = 2'b10;
          w_use_rs1      = 1'b1;
          w_use_rs2      = 1'b1;
        end
        OP_AUIPC: begin
          w_dec.alufn    = ALU_ADD;
          w_dec.alusrc   = 1'b1;
          w_dec.regwrite = 1'b1;
          w_dec.rwsrc    = 2'b00;
        end
        OP_LUI: begin
          w_dec.alufn    = ALU_PASS;
          w_dec.alusrc   = 1'b1;
          w_dec.regwrite = 1'b1;
          w_dec.rwsrc    = 2'b10;
        end
        default: w_dec = nop_bundle();
      endcase
    end
    // x0 is never written; rd is only carried when a write happens
    if (w_rd == 5'd0) w_dec.regwrite = 1'b0;
    w_dec.rd = w_dec.regwrite ? w_rd : 5'd0;
  end

  // Resolve the EX-stage branch/jump from the ALU flags
  always_comb begin
    case (id_ex_q.br)
      BR_EQ:   pc_sel = zf        ? 2'b01 : 2'b00;
      BR_NE:   pc_sel = !zf       ? 2'b01 : 2'b00;
      BR_LT:   pc_sel = (sf != vf) ? 2'b01 : 2'b00;
      BR_GE:   pc_sel = (sf == vf) ? 2'b01 : 2'b00;
      BR_LTU:  pc_sel = !cf       ? 2'b01 : 2'b00;
      BR_GEU:  pc_sel = cf        ? 2'b01 : 2'b00;
      BR_JAL:  pc_sel = 2'b01;
      BR_JALR: pc_sel = 2'b10;
      default: pc_sel = 2'b00;
    endcase
  end

  assign w_taken        = (pc_sel != 2'b00);
  assign hazard_loaduse = id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
                          ((w_use_rs1 && (id_ex_q.rd == w_rs1)) ||
                           (w_use_rs2 && (id_ex_q.rd == w_rs2)));
  // A taken branch squashes the ID instruction anyway, so it overrides the interlock
  assign stall          = hazard_loaduse && LOADUSE_STALL && !w_taken;
  assign flush_ifid     = w_taken && (BR_FLUSH_DEPTH == 2);

  // Next-state of the three bundle registers; bubbles enter at ID/EX
  always_comb begin
    id_ex_d            = (w_taken || stall) ? nop_bundle() : w_dec;
    ex_mem_d.mem_read  = id_ex_q.mem_read;
    ex_mem_d.mem_write = id_ex_q.mem_write;
    ex_mem_d.sizesel   = id_ex_q.sizesel;
    ex_mem_d.munsigned = id_ex_q.munsigned;
    ex_mem_d.regwrite  = id_ex_q.regwrite;
    ex_mem_d.memtoreg  = id_ex_q.memtoreg;
    ex_mem_d.rwsrc     = id_ex_q.rwsrc;
    ex_mem_d.rd        = id_ex_q.rd;
    mem_wb_d.regwrite  = ex_mem_q.regwrite;
    mem_wb_d.memtoreg  = ex_mem_q.memtoreg;
    mem_wb_d.rwsrc     = ex_mem_q.rwsrc;
    mem_wb_d.rd        = ex_mem_q.rd;
  end

  // Pipeline registers; reset drops every in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q  <= nop_bundle();
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign ex_alufn       = id_ex_q.alufn;
  assign ex_alusrc      = id_ex_q.alusrc;
  assign ex_shamt       = id_ex_q.shamt;
  assign mem_read       = ex_mem_q.mem_read;
  assign mem_write      = ex_mem_q.mem_write;
  assign mem_sizesel    = ex_mem_q.sizesel;
  assign mem_unsigned   = ex_mem_q.munsigned;
  assign wb_regwrite    = mem_wb_q.regwrite;
  assign wb_memtoreg    = mem_wb_q.memtoreg;
  assign wb_regwritesrc = mem_wb_q.rwsrc;
  assign wb_rd          = mem_wb_q.rd;

endmodule
`default_nettype wire
